// File: rtl/ysyx_23060111_wbu_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060111_wbu_if
// Bundle of the signals that connect the writeback unit to its neighbours.
// The unit uses the slave modport. The producer, the regfile arbiter and the
// decode-side hazard logic together use the master modport.
//
// Signal groups:
//   result in  : in_valid, in_ready, in_rd, in_data, in_is_load, in_funct3,
//                in_addr_lo
//   regfile    : wr_gnt, wen, waddr, wdata
//   hazard     : q_raddr1/2 (query), q_hit1/2, q_data1/2 (answer)
// ----------------------------------------------------------------------------
interface ysyx_23060111_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_is_load;
    logic [2:0]            in_funct3;
    logic [1:0]            in_addr_lo;

    logic                  wr_gnt;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    logic [ADDR_WIDTH-1:0] q_raddr1;
    logic [ADDR_WIDTH-1:0] q_raddr2;
    logic                  q_hit1;
    logic                  q_hit2;
    logic [DATA_WIDTH-1:0] q_data1;
    logic [DATA_WIDTH-1:0] q_data2;

    modport slave (
        input  in_valid, in_rd, in_data, in_is_load, in_funct3, in_addr_lo,
        input  wr_gnt, q_raddr1, q_raddr2,
        output in_ready, wen, waddr, wdata, q_hit1, q_hit2, q_data1, q_data2
    );

    modport master (
        output in_valid, in_rd, in_data, in_is_load, in_funct3, in_addr_lo,
        output wr_gnt, q_raddr1, q_raddr2,
        input  in_ready, wen, waddr, wdata, q_hit1, q_hit2, q_data1, q_data2
    );
endinterface

// File: rtl/ysyx_23060111_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_23060111_wbu
// Writeback unit. It accepts results over a valid/ready handshake and formats
// load data by size, sign and byte offset. Results are queued in an in-order
// circular FIFO and drained one per cycle onto the regfile write port when
// wr_gnt allows it. It also reports pending destinations so that decode can
// detect RAW hazards.
//
// Ports:
//   clk    : clock; all state changes on posedge
//   rst_n  : synchronous active-low reset
//   bus    : ysyx_23060111_wbu_if.slave (result in, regfile out, hazard query)
//
// Optional build macro YSYX_23060111_WBU_BYPASS_EN:
//   defined   -> q_dataK returns the data of the youngest pending entry that
//                matches q_raddrK
//   undefined -> q_dataK is tied to 0
// ----------------------------------------------------------------------------
module ysyx_23060111_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_23060111_wbu_if.slave       bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // NOTE: FIFO storage carries no reset. The count and pointers alone decide
    // which slots are valid, so stale contents are never observed.
    logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic                  full;
    logic                  push;
    logic                  enq;
    logic                  pop;
    logic                  wen;
    logic [DATA_WIDTH-1:0] fmt_data;

    // The pointer wraps explicitly, so a DEPTH that is not a power of two works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    assign full = (count_q == CNT_W'(DEPTH));
    // When the FIFO is full, no input is accepted, even on a cycle that pops.
    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready;
    // A write to x0 completes the handshake but is dropped.
    assign enq          = push && (bus.in_rd != '0);
    assign wen          = rst_n && (count_q != '0);
    assign pop          = wen && bus.wr_gnt;

    // ------------------------------------------------------------------
    // Load formatting. Byte and halfword lanes come from in_addr_lo.
    // ------------------------------------------------------------------
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        fmt_data = bus.in_data;
        case (bus.in_addr_lo)
            2'd0:    byte_sel = bus.in_data[7:0];
            2'd1:    byte_sel = bus.in_data[15:8];
            2'd2:    byte_sel = bus.in_data[23:16];
            default: byte_sel = bus.in_data[31:24];
        endcase
        half_sel = bus.in_addr_lo[1] ? bus.in_data[31:16] : bus.in_data[15:0];
        if (bus.in_is_load) begin
            case (bus.in_funct3)
                3'b000:  fmt_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
                3'b100:  fmt_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
                3'b001:  fmt_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                3'b101:  fmt_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                default: fmt_data = bus.in_data;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointer and count next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wr_ptr_q]   <= bus.in_rd;
            data_mem[wr_ptr_q] <= fmt_data;
        end
    end

    // The regfile port shows the head entry and is zeroed when idle or in reset.
    assign bus.wen   = wen;
    assign bus.waddr = wen ? rd_mem[rd_ptr_q]   : '0;
    assign bus.wdata = wen ? data_mem[rd_ptr_q] : '0;

    // ------------------------------------------------------------------
    // Hazard lookup. The walk goes from oldest to youngest, so the last match
    // is the youngest one and supplies the bypass data.
    // ------------------------------------------------------------------
    logic                  hit1, hit2;
`ifdef YSYX_23060111_WBU_BYPASS_EN
    logic [DATA_WIDTH-1:0] byp1, byp2;
`endif

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
`ifdef YSYX_23060111_WBU_BYPASS_EN
        byp1 = '0;
        byp2 = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            int slot;
            slot = int'(rd_ptr_q) + k;
            if (slot >= DEPTH) slot = slot - DEPTH;
            if (k < int'(count_q)) begin
                if (rd_mem[PTR_W'(slot)] == bus.q_raddr1) begin
                    hit1 = 1'b1;
`ifdef YSYX_23060111_WBU_BYPASS_EN
                    byp1 = data_mem[PTR_W'(slot)];
`endif
                end
                if (rd_mem[PTR_W'(slot)] == bus.q_raddr2) begin
                    hit2 = 1'b1;
`ifdef YSYX_23060111_WBU_BYPASS_EN
                    byp2 = data_mem[PTR_W'(slot)];
`endif
                end
            end
        end
    end

    assign bus.q_hit1 = rst_n && (bus.q_raddr1 != '0) && hit1;
    assign bus.q_hit2 = rst_n && (bus.q_raddr2 != '0) && hit2;

`ifdef YSYX_23060111_WBU_BYPASS_EN
    assign bus.q_data1 = bus.q_hit1 ? byp1 : '0;
    assign bus.q_data2 = bus.q_hit2 ? byp2 : '0;
`else
    assign bus.q_data1 = '0;
    assign bus.q_data2 = '0;
`endif

endmodule
